// File: rtl/fmul_issuer.sv
// Initiator for a single-precision multiplier: queues operand pairs, issues them one
// at a time, and returns results downstream in acceptance order.
module fmul_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] mul_din1,
  output logic [31:0] mul_din2,
  output logic        mul_din_rdy,
  input  logic [31:0] mul_dout,
  input  logic        mul_dout_rdy,
  output logic [31:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        err,
  output logic [15:0] done_cnt,
  output logic [2:0]  fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_HOLD     = 3'd4
  } state_t;

  state_t          state;
  logic            boot_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [31:0]     mem_a [FIFO_DEPTH];
  logic [31:0]     mem_b [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // in_ready depends only on local registers, never on res_ready.
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign in_ready  = (state != ST_BOOT) && !full;
  assign push      = in_valid && in_ready;
  assign pop       = (state == ST_ISSUE);
  assign busy      = !((state == ST_IDLE) && empty);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // The multiplier needs a cycle to settle after reset, so BOOT spans two cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_BOOT;
      boot_cnt    <= 1'b0;
      wait_cnt    <= '0;
      mul_din_rdy <= 1'b0;
      mul_din1    <= '0;
      mul_din2    <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      err         <= 1'b0;
      done_cnt    <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (boot_cnt) state <= ST_IDLE;
          else          boot_cnt <= 1'b1;
        end
        ST_IDLE: begin
          if (!empty && !res_valid) begin
            state       <= ST_ISSUE;
            mul_din_rdy <= 1'b1;
            mul_din1    <= mem_a[rd_ptr];
            mul_din2    <= mem_b[rd_ptr];
          end
        end
        ST_ISSUE: begin
          mul_din_rdy <= 1'b0;
          wait_cnt    <= '0;
          state       <= ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          if (mul_dout_rdy) begin
            res_data  <= mul_dout;
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            res_data  <= QNAN;
            res_valid <= 1'b1;
            err       <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        ST_HOLD: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_issuer.sv
// Bench for fmul_issuer: directed operand pairs, a table-driven multiplier responder,
// and issue/result monitors that pop expected values from queues.
module tb_fmul_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mul_din1;
  logic [31:0] mul_din2;
  logic        mul_din_rdy;
  logic [31:0] mul_dout;
  logic        mul_dout_rdy;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        busy;
  logic        err;
  logic [15:0] done_cnt;
  logic [2:0]  fsm_state;

  fmul_issuer dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready), .mul_din1(mul_din1), .mul_din2(mul_din2),
    .mul_din_rdy(mul_din_rdy), .mul_dout(mul_dout), .mul_dout_rdy(mul_dout_rdy),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .err(err), .done_cnt(done_cnt), .fsm_state(fsm_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [63:0] iss_q[$];
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int res_count = 0;
  int iss_count = 0;
  int exp_done = 0;
  int last_issue_cyc = 0;
  int rise_cyc = 0;
  bit resp_enable = 1'b1;
  int resp_delay = 1;
  int spur_cnt = 0;
  int spur_seen = 0;
  logic        mon_pv = 1'b0;
  logic        mon_ph = 1'b0;
  logic [31:0] mon_pd = '0;
  logic        iss_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000;  // 2.0 * 3.0
      64'h3FC00000_40000000: return 32'h40400000;  // 1.5 * 2.0
      64'hBF800000_40800000: return 32'hC0800000;  // -1.0 * 4.0
      64'h3F000000_3F000000: return 32'h3E800000;  // 0.5 * 0.5
      64'h40400000_40400000: return 32'h41100000;  // 3.0 * 3.0
      64'h3F800000_40E00000: return 32'h40E00000;  // 1.0 * 7.0
      default:               return 32'h00000000;
    endcase
  endfunction

  // ---------------- multiplier responder ----------------
  initial begin
    logic [31:0] ra, rb;
    mul_dout = '0;
    mul_dout_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (spur_seen != spur_cnt) begin
        mul_dout = 32'h12345678;
        mul_dout_rdy = 1'b1;
        @(negedge clk);
        mul_dout_rdy = 1'b0;
        spur_seen++;
      end else if (mul_din_rdy && !rst && resp_enable) begin
        ra = mul_din1;
        rb = mul_din2;
        repeat (resp_delay) @(negedge clk);
        mul_dout = mul_ref(ra, rb);
        mul_dout_rdy = 1'b1;
        @(negedge clk);
        mul_dout_rdy = 1'b0;
      end
    end
  end

  // ---------------- issue monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        iss_prev = 1'b0;
      end else begin
        if (mul_din_rdy) begin
          checks++;
          if (iss_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue actual=%h_%h required=none", mul_din1, mul_din2);
          end else begin
            e = iss_q.pop_front();
            if ({mul_din1, mul_din2} !== e) begin
              errors++;
              $display("FAIL issue_operands actual=%h_%h required=%h", mul_din1, mul_din2, e);
            end
          end
          checks++;
          if (res_valid || mul_dout_rdy || iss_prev) begin
            errors++;
            $display("FAIL issue_overlap actual=%b%b%b required=000", res_valid, mul_dout_rdy, iss_prev);
          end
          iss_count++;
          last_issue_cyc = cyc;
        end
        iss_prev = mul_din_rdy;
      end
    end
  end

  // ---------------- result monitor ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_pv = 1'b0;
        mon_ph = 1'b0;
      end else begin
        if (res_valid && !mon_pv) rise_cyc = cyc;
        if (mon_ph && res_valid) begin
          checks++;
          if (res_data !== mon_pd) begin
            errors++;
            $display("FAIL res_hold_stable actual=%h required=%h", res_data, mon_pd);
          end
        end
        if (res_valid && res_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result actual=%h required=none", res_data);
          end else begin
            e = exp_q.pop_front();
            if (res_data !== e) begin
              errors++;
              $display("FAIL result_data actual=%h required=%h", res_data, e);
            end
          end
          res_count++;
          exp_done++;
        end
        mon_pv = res_valid;
        mon_ph = res_valid && !res_ready;
        mon_pd = res_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    int n;
    @(posedge clk); #2;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=0 required=1");
    end else begin
      iss_q.push_back({a, b});
      exp_q.push_back(p);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target, input int budget);
    int n;
    n = 0;
    while (res_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (res_count < target) begin
      errors++;
      $display("FAIL result_timeout actual=%0d required=%0d", res_count, target);
    end
    @(negedge clk);
  endtask

  task automatic wait_issue(input int target, input int budget);
    int n;
    n = 0;
    while (iss_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (iss_count < target) begin
      errors++;
      $display("FAIL issue_timeout actual=%0d required=%0d", iss_count, target);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!res_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_arrives", {31'd0, res_valid}, 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int rel_cyc;
    int n;
    int seen;
    int target;

    #1 rst = 1'b1;
    in_a = 32'h40000000;
    in_b = 32'h40400000;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_din_rdy", {31'd0, mul_din_rdy}, 32'd0);
    check("rst_din1", mul_din1, 32'd0);
    check("rst_din2", mul_din2, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_state_boot", {29'd0, fsm_state}, 32'd0);

    // in_valid already high at reset release: boot lasts two cycles.
    @(posedge clk); #2;
    rst = 1'b0;
    rel_cyc = cyc;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("boot_in_ready_cycle", cyc - rel_cyc, 32'd2);
    iss_q.push_back({32'h40000000, 32'h40400000});
    exp_q.push_back(32'h40C00000);
    @(posedge clk); #2;
    in_valid = 1'b0;
    wait_results(1, 50);
    checks++;
    if (last_issue_cyc - rel_cyc < 3) begin
      errors++;
      $display("FAIL first_issue_cycle actual=%0d required>=3", last_issue_cyc - rel_cyc);
    end
    check("done_cnt_first", {16'd0, done_cnt}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Held result blocks issue; four more pairs fill the FIFO; a fifth is refused.
    res_ready = 1'b0;
    push_pair(32'h40000000, 32'h40400000, 32'h40C00000);
    wait_valid(50);
    push_pair(32'h3FC00000, 32'h40000000, 32'h40400000);
    push_pair(32'hBF800000, 32'h40800000, 32'hC0800000);
    push_pair(32'h3F000000, 32'h3F000000, 32'h3E800000);
    push_pair(32'h40400000, 32'h40400000, 32'h41100000);
    @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #2;
    in_a = 32'h3F800000;
    in_b = 32'h40E00000;
    in_valid = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) seen++;
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    check("fifth_refused", seen, 32'd0);
    res_ready = 1'b1;
    wait_results(6, 300);
    check("done_cnt_after_drain", {16'd0, done_cnt}, 32'd6);

    // Back-to-back pairs with a slower responder.
    resp_delay = 3;
    push_pair(32'h3FC00000, 32'h40000000, 32'h40400000);
    push_pair(32'hBF800000, 32'h40800000, 32'hC0800000);
    push_pair(32'h3F000000, 32'h3F000000, 32'h3E800000);
    wait_results(9, 200);
    check("done_cnt_b2b", {16'd0, done_cnt}, exp_done);
    resp_delay = 1;

    // Silent responder: timeout yields quiet NaN and sticky err.
    resp_enable = 1'b0;
    push_pair(32'h40400000, 32'h40400000, 32'h7FC00000);
    wait_issue(10, 50);
    wait_results(10, 400);
    check("timeout_latency", rise_cyc - last_issue_cyc, 32'd256);
    check("timeout_err", {31'd0, err}, 32'd1);
    resp_enable = 1'b1;
    push_pair(32'h3F800000, 32'h40E00000, 32'h40E00000);
    wait_results(11, 50);
    check("err_sticky", {31'd0, err}, 32'd1);
    check("done_cnt_after_timeout", {16'd0, done_cnt}, 32'd11);

    // Spurious completion pulse while idle.
    spur_cnt++;
    repeat (6) @(negedge clk);
    check("spur_res_valid", {31'd0, res_valid}, 32'd0);
    check("spur_done_cnt", {16'd0, done_cnt}, 32'd11);
    check("spur_busy", {31'd0, busy}, 32'd0);

    // Reset while waiting on a result with two pairs still queued.
    resp_enable = 1'b0;
    res_ready = 1'b0;
    push_pair(32'h40000000, 32'h40400000, 32'h40C00000);
    push_pair(32'h40400000, 32'h40400000, 32'h41100000);
    push_pair(32'h3F800000, 32'h40E00000, 32'h40E00000);
    wait_issue(12, 20);
    repeat (2) @(negedge clk);
    check("pre_rst_state_wait", {29'd0, fsm_state}, 32'd3);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst_din_rdy", {31'd0, mul_din_rdy}, 32'd0);
    check("mid_rst_din1", mul_din1, 32'd0);
    check("mid_rst_din2", mul_din2, 32'd0);
    check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("mid_rst_res_data", res_data, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_done_cnt", {16'd0, done_cnt}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    iss_q.delete();
    exp_q.delete();
    exp_done = 0;
    @(posedge clk); #2;
    rst = 1'b0;
    spur_cnt++;
    repeat (6) @(negedge clk);
    spur_cnt++;
    repeat (6) @(negedge clk);
    check("post_rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("post_rst_done_cnt", {16'd0, done_cnt}, 32'd0);
    check("post_rst_fifo_empty", {31'd0, busy}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    resp_enable = 1'b1;
    res_ready = 1'b1;
    target = res_count + 1;
    push_pair(32'h40000000, 32'h40400000, 32'h40C00000);
    wait_results(target, 50);
    check("post_rst_done_cnt_one", {16'd0, done_cnt}, 32'd1);
    check("post_rst_err_clear", {31'd0, err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
